// File: rtl/alu_flag_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_flag_seq_pkg
// Shared definitions for the chunked add/subtract flag unit and the compare
// stage that consumes its flags.
//   state_t     : sequencer state encoding (IDLE, RUN, DONE)
//   WIDTH_DEF   : default operand/result width
//   CHUNK_DEF   : default bits added per cycle
//   flags_t     : {z, v, n} flag bundle handed to the compare stage
//   flag_rules  : selects the V/N meaning from the sign/sub mode
// -----------------------------------------------------------------------------
package alu_flag_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Flag rules from the final chunk. In signed mode n is the true sign of the
  // exact result, so after a subtract it is the signed less-than. Unsigned
  // subtract reports the borrow (~cout) as less-than; unsigned add reports the
  // carry-out as overflow.
  function automatic flags_t flag_rules(input logic sign,
                                        input logic sub,
                                        input logic zero,
                                        input logic cout,
                                        input logic cmsb,
                                        input logic msb);
    flags_t f;
    logic   ovf;
    ovf = cout ^ cmsb;
    f.z = zero;
    if (sign) begin
      f.v = ovf;
      f.n = msb ^ ovf;
    end else if (sub) begin
      f.v = 1'b0;
      f.n = ~cout;
    end else begin
      f.v = cout;
      f.n = msb;
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_chunk_add.sv
// -----------------------------------------------------------------------------
// alu_chunk_add
// Combinational CHUNK-bit adder slice. Besides the sum and carry-out it
// exposes the carry into the top bit, which the parent needs to form the
// signed-overflow flag on the last chunk.
//   a, b  : chunk operands (b already inverted for subtract)
//   cin   : carry in
//   sum   : chunk sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit
// CHUNK must be at least 2.
// -----------------------------------------------------------------------------
module alu_chunk_add
  #(parameter int CHUNK = 8)
  (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
  );

  logic [CHUNK-1:0] low_s;

  // Add the lower CHUNK-1 bits one bit wider so the carry into the MSB falls
  // out as the top bit of this partial sum.
  assign low_s = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
  assign cmsb  = low_s[CHUNK-1];
  assign sum   = {a[CHUNK-1] ^ b[CHUNK-1] ^ cmsb, low_s[CHUNK-2:0]};
  assign cout  = (a[CHUNK-1] & b[CHUNK-1]) | (cmsb & (a[CHUNK-1] ^ b[CHUNK-1]));

endmodule

// File: rtl/alu_flag_seq.sv
// -----------------------------------------------------------------------------
// alu_flag_seq
// Multi-cycle add/subtract producing the 32-bit result plus Z/V/N flags for the
// compare stage. Operands are added CHUNK bits per cycle, LSB first, under a
// start/done handshake; one result per NCHUNK+1 cycles back-to-back.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   start : request, accepted in IDLE or DONE, ignored in RUN
//   a, b  : operands, latched on the accepting edge
//   sub   : 1 = a-b, 0 = a+b
//   sign  : 1 = signed flag rules, 0 = unsigned flag rules
//   busy  : high while chunks are being added
//   done  : one-cycle pulse, result and flags valid from this cycle
//   sum   : result (held until the next completion)
//   z/v/n : zero / overflow / negative-or-less-than flags
// Build option: define ALU_FLAG_OUTREG_EN to add one register stage on sum,
// z, v, n and done (done one cycle later; start acceptance unchanged).
// -----------------------------------------------------------------------------
module alu_flag_seq
  import alu_flag_seq_pkg::*;
  #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             z,
    output logic             v,
    output logic             n
  );

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCHUNK - 1);

  state_t           state_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic             zacc_r;
  logic             sub_r;
  logic             sign_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_q_r;
  flags_t           flags_r;

  logic [CHUNK-1:0] csum_s;
  logic             cout_s;
  logic             cmsb_s;
  logic             zacc_nxt_s;
  logic [WIDTH-1:0] sum_nxt_s;

  // The operand registers shift right each RUN cycle, so the active chunk is
  // always the low CHUNK bits and one adder serves every chunk.
  alu_chunk_add #(.CHUNK(CHUNK)) u_add (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .sum  (csum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // Chunk sums enter at the top of the result shift register; after NCHUNK
  // cycles the first chunk has reached bit 0.
  assign sum_nxt_s  = {csum_s, sum_sh_r[WIDTH-1:CHUNK]};
  assign zacc_nxt_s = zacc_r & (csum_s == {CHUNK{1'b0}});

  // Sequencer: operand latching, chunk stepping and result/flag capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNTW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      zacc_r   <= 1'b0;
      sub_r    <= 1'b0;
      sign_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_q_r  <= {WIDTH{1'b0}};
      flags_r  <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b here, the +1 is the carry-in.
            a_r      <= a;
            b_r      <= b ^ {WIDTH{sub}};
            sub_r    <= sub;
            sign_r   <= sign;
            carry_r  <= sub;
            zacc_r   <= 1'b1;
            cnt_r    <= {CNTW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_r      <= {{CHUNK{1'b0}}, a_r[WIDTH-1:CHUNK]};
          b_r      <= {{CHUNK{1'b0}}, b_r[WIDTH-1:CHUNK]};
          sum_sh_r <= sum_nxt_s;
          carry_r  <= cout_s;
          zacc_r   <= zacc_nxt_s;
          cnt_r    <= cnt_r + CNTW'(1'b1);
          if (cnt_r == CNT_LAST) begin
            sum_q_r <= sum_nxt_s;
            flags_r <= flag_rules(sign_r, sub_r, zacc_nxt_s, cout_s, cmsb_s,
                                  csum_s[CHUNK-1]);
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          cnt_r   <= {CNTW{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;

`ifdef ALU_FLAG_OUTREG_EN
  logic [WIDTH-1:0] sum_o_r;
  flags_t           flags_o_r;
  logic             done_o_r;

  // Extra output stage: retimes result, flags and done by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_o_r   <= {WIDTH{1'b0}};
      flags_o_r <= 3'b000;
      done_o_r  <= 1'b0;
    end else begin
      sum_o_r   <= sum_q_r;
      flags_o_r <= flags_r;
      done_o_r  <= done_r;
    end
  end

  assign done = done_o_r;
  assign sum  = sum_o_r;
  assign z    = flags_o_r.z;
  assign v    = flags_o_r.v;
  assign n    = flags_o_r.n;
`else
  assign done = done_r;
  assign sum  = sum_q_r;
  assign z    = flags_r.z;
  assign v    = flags_r.v;
  assign n    = flags_r.n;
`endif

endmodule

// File: tb/tb_alu_flag_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_flag_seq
// Directed and randomized checks of alu_flag_seq against an arithmetic
// reference model (exact signed/unsigned integer results, not carry chains).
// -----------------------------------------------------------------------------
module tb_alu_flag_seq;

`ifdef ALU_FLAG_OUTREG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  localparam int NCH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        z;
  logic        v;
  logic        n;

  int          vectors;
  int          fails;
  int          lat;
  int          bcnt;
  int          pulses;
  logic [31:0] exp_sum;
  logic        exp_z;
  logic        exp_v;
  logic        exp_n;

  alu_flag_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .sign  (sign),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .z     (z),
    .v     (v),
    .n     (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer results, flags read off the true mathematical value.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       input logic msub, input logic msign);
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ur = msub ? (ua - ub) : (ua + ub);
    exp_sum = ur[31:0];
    exp_z   = (exp_sum == 32'd0);
    if (msign) begin
      sr    = msub ? (sa - sb) : (sa + sb);
      exp_v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      exp_n = (sr < 64'sd0);
    end else if (msub) begin
      exp_v = 1'b0;
      exp_n = (ua < ub);
    end else begin
      exp_v = (ur > 64'sd4294967295);
      exp_n = exp_sum[31];
    end
  endtask

  // Called at a negedge: drive start for one cycle, then scramble operands.
  task automatic start_op(input logic [31:0] sa, input logic [31:0] sb,
                          input logic ssub, input logic ssign);
    model(sa, sb, ssub, ssign);
    start = 1'b1;
    a     = sa;
    b     = sb;
    sub   = ssub;
    sign  = ssign;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom_range(0, 1));
    sign  = 1'($urandom_range(0, 1));
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  // Bounded wait for done; lat counts cycles after the accepting edge.
  task automatic wait_done(output int wl, output int wb);
    wl = 0;
    wb = 0;
    while (done !== 1'b1 && wl < 30) begin
      if (busy === 1'b1) wb++;
      @(negedge clk);
      wl++;
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_z"}, {31'd0, z}, {31'd0, exp_z});
    chk({tag, "_v"}, {31'd0, v}, {31'd0, exp_v});
    chk({tag, "_n"}, {31'd0, n}, {31'd0, exp_n});
  endtask

  initial begin
    vectors = 0;
    fails   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    sub     = 1'b0;
    sign    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {29'd0, z, v, n}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 5 - 5 signed: zero result, busy exactly NCHUNK cycles
    start_op(32'd5, 32'd5, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    chk("eq_lat", 32'(lat), 32'(LAT));
    chk("eq_busy_cycles", 32'(bcnt), 32'(NCH));
    chk_result("eq");
    chk("eq_sum_const", {sum, 1'b0} == 33'd0 ? 32'd1 : 32'd0, {31'd0, exp_z});
    @(negedge clk);
    chk("eq_done_single", {31'd0, done}, 32'd0);

    // signed overflow on subtract
    start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    chk("ovf_lat", 32'(lat), 32'(LAT));
    chk_result("ovf");
    chk("ovf_sum_const", sum, 32'h8000_0000);

    // 1 - 2 unsigned, then signed
    @(negedge clk);
    start_op(32'd1, 32'd2, 1'b1, 1'b0);
    wait_done(lat, bcnt);
    chk_result("ult");
    @(negedge clk);
    start_op(32'd1, 32'd2, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    chk_result("slt");

    // unsigned add wrap, then back-to-back start in the done cycle
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    chk_result("wrap");
    start_op(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(lat, bcnt);
    chk("b2b_lat", 32'(lat + 1), 32'(LAT + 1));
    chk_result("b2b");
    chk("b2b_sum_const", sum, 32'd7);

    // start pulsed in the 2nd RUN cycle is ignored
    @(negedge clk);
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignore_lat", 32'(lat + 1), 32'(LAT));
    chk_result("ignore");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("ignore_one_pulse", 32'(pulses), 32'd0);

    // reset in the 3rd RUN cycle discards the operation
    start_op(32'd1, 32'd2, 1'b1, 1'b1);
    wait_done(lat, bcnt);
    chk_result("pre_rst");
    @(negedge clk);
    start_op(32'hCAFE_0000, 32'h0000_F00D, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_flags", {29'd0, z, v, n}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("post_rst_quiet", 32'(pulses), 32'd0);

    // randomized operations, including back-to-back starts
    for (int i = 0; i < 30; i++) begin
      start_op($urandom, (i % 5 == 0) ? 32'h8000_0000 : $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(lat, bcnt);
      chk("rnd_lat", 32'(lat), 32'(LAT));
      chk_result("rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
